// File: rtl/data_path_param.sv
// Parameterised CPU datapath: IR/MAR/PC, general register file, CCR, BUS1/BUS2 muxing.
// Optional downward-growing hardware stack pointer, compiled in with DATA_PATH_STACK_EN.
module data_path_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int NREGS       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int RS_W       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              mar_load,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              reg_load,
  input  logic              ccr_load,
  input  logic [RS_W-1:0]   reg_wsel,
  input  logic [RS_W-1:0]   reg_asel,
  input  logic [RS_W-1:0]   reg_bsel,
  input  logic [1:0]        bus1_sel,
  input  logic [1:0]        bus2_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzvc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] from_memory,
  output logic [DATA_W-1:0] to_memory,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        ccr,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              err_clr,
  output logic              sp_full,
  output logic              sp_empty,
  output logic              stack_err
);

  logic [DATA_W-1:0]             ir_q, ir_d;
  logic [ADDR_W-1:0]             mar_q, mar_d;
  logic [ADDR_W-1:0]             pc_q, pc_d;
  logic [3:0]                    ccr_q, ccr_d;
  logic [NREGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [DATA_W-1:0]             bus1, bus2, sp_bus;

`ifdef DATA_PATH_STACK_EN
  localparam logic [ADDR_W-1:0] STACK_TOP = '1;
  localparam logic [ADDR_W-1:0] STACK_LIM = STACK_TOP - ADDR_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              stack_err_q, stack_err_d;

  assign sp_full   = (sp_q == STACK_LIM);
  assign sp_empty  = (sp_q == STACK_TOP);
  assign stack_err = stack_err_q;
  assign sp_bus    = DATA_W'(sp_q);

  // An error in the same cycle as err_clr wins, so it is applied last.
  always_comb begin
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    if (err_clr) stack_err_d = 1'b0;
    if (sp_push && !sp_pop) begin
      if (sp_full) stack_err_d = 1'b1;
      else         sp_d        = sp_q - 1'b1;
    end else if (sp_pop && !sp_push) begin
      if (sp_empty) stack_err_d = 1'b1;
      else          sp_d        = sp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q        <= STACK_TOP;
      stack_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end
`else
  logic unused_stack_in;
  assign unused_stack_in = sp_push ^ sp_pop ^ err_clr;
  assign sp_full   = 1'b0;
  assign sp_empty  = 1'b1;
  assign stack_err = 1'b0;
  assign sp_bus    = '0;
`endif

  always_comb begin
    bus1 = '0;
    case (bus1_sel)
      2'b00:   bus1 = DATA_W'(pc_q);
      2'b01:   bus1 = regs_q[reg_asel];
      2'b10:   bus1 = sp_bus;
      default: bus1 = '0;
    endcase
  end

  always_comb begin
    bus2 = '0;
    case (bus2_sel)
      2'b00:   bus2 = alu_result;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = from_memory;
      default: bus2 = '0;
    endcase
  end

  assign to_memory = bus1;
  assign alu_a     = bus1;
  assign alu_b     = regs_q[reg_bsel];
  assign ir        = ir_q;
  assign address   = mar_q;
  assign ccr       = ccr_q;

  always_comb begin
    ir_d   = ir_load  ? bus2 : ir_q;
    mar_d  = mar_load ? bus2[ADDR_W-1:0] : mar_q;
    ccr_d  = ccr_load ? alu_nzvc : ccr_q;
    pc_d   = pc_q;
    if (pc_load)     pc_d = bus2[ADDR_W-1:0];
    else if (pc_inc) pc_d = pc_q + 1'b1;
    regs_d = regs_q;
    if (reg_load) regs_d[reg_wsel] = bus2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q   <= '0;
      mar_q  <= '0;
      pc_q   <= '0;
      ccr_q  <= '0;
      regs_q <= '0;
    end else begin
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      pc_q   <= pc_d;
      ccr_q  <= ccr_d;
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_data_path_param.sv
// Self-checking bench for data_path_param: directed table, stack/reset sequences, random vs model.
module tb_data_path_param;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ir_load, mar_load, pc_load, pc_inc, reg_load, ccr_load;
  logic [1:0] reg_wsel, reg_asel, reg_bsel, bus1_sel, bus2_sel;
  logic [7:0] alu_result, from_memory;
  logic [3:0] alu_nzvc;
  logic [7:0] alu_a, alu_b, to_memory, ir, address;
  logic [3:0] ccr;
  logic       sp_push, sp_pop, err_clr, sp_full, sp_empty, stack_err;

  int checks = 0;
  int errors = 0;

  data_path_param #(.DATA_W(8), .ADDR_W(8), .NREGS(4), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset),
    .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load), .pc_inc(pc_inc),
    .reg_load(reg_load), .ccr_load(ccr_load),
    .reg_wsel(reg_wsel), .reg_asel(reg_asel), .reg_bsel(reg_bsel),
    .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .alu_result(alu_result), .alu_nzvc(alu_nzvc), .alu_a(alu_a), .alu_b(alu_b),
    .from_memory(from_memory), .to_memory(to_memory),
    .ir(ir), .address(address), .ccr(ccr),
    .sp_push(sp_push), .sp_pop(sp_pop), .err_clr(err_clr),
    .sp_full(sp_full), .sp_empty(sp_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state as plain integers; stack kept as an item count.
  int m_pc, m_mar, m_ir, m_ccr, m_cnt, m_err;
  int m_r[4];
`ifdef DATA_PATH_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_bus1();
    case (bus1_sel)
      2'd0:    return m_pc;
      2'd1:    return m_r[reg_asel];
      2'd2:    return STACK ? 255 - m_cnt : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int m_bus2();
    case (bus2_sel)
      2'd0:    return int'(alu_result);
      2'd1:    return m_bus1();
      2'd2:    return int'(from_memory);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_ccr = 0; m_cnt = 0; m_err = 0;
    foreach (m_r[i]) m_r[i] = 0;
  endtask

  task automatic model_check();
    chk("to_memory", to_memory, m_bus1());
    chk("alu_a", alu_a, m_bus1());
    chk("alu_b", alu_b, m_r[reg_bsel]);
    chk("address", address, m_mar);
    chk("ir", ir, m_ir);
    chk("ccr", ccr, m_ccr);
    chk("sp_full", sp_full, (STACK && m_cnt == SD) ? 1 : 0);
    chk("sp_empty", sp_empty, (!STACK || m_cnt == 0) ? 1 : 0);
    chk("stack_err", stack_err, m_err);
  endtask

  task automatic model_clk();
    int b2;
    b2 = m_bus2();
    if (ir_load)  m_ir  = b2;
    if (mar_load) m_mar = b2 % 256;
    if (ccr_load) m_ccr = int'(alu_nzvc);
    if (pc_load)     m_pc = b2 % 256;
    else if (pc_inc) m_pc = (m_pc + 1) % 256;
    if (reg_load) m_r[reg_wsel] = b2;
    if (STACK) begin
      if (err_clr) m_err = 0;
      if (sp_push && !sp_pop) begin
        if (m_cnt == SD) m_err = 1; else m_cnt++;
      end else if (sp_pop && !sp_push) begin
        if (m_cnt == 0) m_err = 1; else m_cnt--;
      end
    end
  endtask

  // Entered just after a falling edge with inputs set; leaves at the next falling edge.
  task automatic cycle();
    #1;
    model_check();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic idle();
    ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0; reg_load = 0; ccr_load = 0;
    reg_wsel = 0; reg_asel = 0; reg_bsel = 0; bus1_sel = 0; bus2_sel = 0;
    alu_result = 0; alu_nzvc = 0; from_memory = 0;
    sp_push = 0; sp_pop = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    idle();
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    logic [1:0] b1, b2;
    logic [7:0] fm;
    logic       rl;
    logic [1:0] ws, as, bs;
    logic       pl, pi;
    logic [7:0] exp_tm, exp_b;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] push_exp[5];

  initial begin
    idle();
    model_reset();
    #12;
    #1;
    chk("rst_address", address, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ccr", ccr, 0);
    chk("rst_sp_empty", sp_empty, 1);
    chk("rst_sp_full", sp_full, 0);
    @(negedge clk);
    reset = 1;

    // Directed table: register transfer, read-before-write, PC wrap and load priority.
    vecs[0] = '{2'd3, 2'd2, 8'h5A, 1'b1, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{2'd1, 2'd1, 8'h00, 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 8'h5A, 8'h5A};
    vecs[2] = '{2'd1, 2'd2, 8'h11, 1'b1, 2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 8'h5A, 8'h5A};
    vecs[3] = '{2'd1, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 8'h11, 8'h11};
    vecs[4] = '{2'd0, 2'd2, 8'hFF, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 8'hFF, 8'h5A};
    vecs[6] = '{2'd0, 2'd2, 8'h10, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{2'd0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h10, 8'h00};
    foreach (vecs[i]) begin
      bus1_sel = vecs[i].b1; bus2_sel = vecs[i].b2; from_memory = vecs[i].fm;
      reg_load = vecs[i].rl; reg_wsel = vecs[i].ws; reg_asel = vecs[i].as;
      reg_bsel = vecs[i].bs; pc_load = vecs[i].pl; pc_inc = vecs[i].pi;
      #1;
      chk($sformatf("vec%0d_to_memory", i), to_memory, vecs[i].exp_tm);
      chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_tm);
      chk($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset in mid-cycle discards state and pending loads.
    do_reset();
    from_memory = 8'h33; bus2_sel = 2'd2; reg_load = 1; reg_wsel = 0;
    ccr_load = 1; alu_nzvc = 4'hF; mar_load = 1; ir_load = 1;
    cycle();
    idle();
    bus1_sel = 2'd1; reg_asel = 0;
    #1;
    chk("pre_rst_R0", to_memory, 8'h33);
    chk("pre_rst_ccr", ccr, 4'hF);
    from_memory = 8'h33; bus2_sel = 2'd2; reg_load = 1; ccr_load = 1; alu_nzvc = 4'hF;
    #1;
    reset = 0;
    #1;
    chk("async_rst_R0", to_memory, 0);
    chk("async_rst_ccr", ccr, 0);
    chk("async_rst_address", address, 0);
    chk("async_rst_ir", ir, 0);
    bus1_sel = 2'd2;
    #1;
    chk("async_rst_sp", to_memory, STACK ? 8'hFF : 8'h00);
    @(negedge clk);
    reset = 1;
    idle();
    model_reset();
    bus1_sel = 2'd1;
    cycle();

`ifdef DATA_PATH_STACK_EN
    do_reset();
    push_exp = '{8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFB};
    bus1_sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      sp_push = 1;
      cycle();
      #1;
      chk($sformatf("push%0d_sp", i), to_memory, push_exp[i]);
      chk($sformatf("push%0d_full", i), sp_full, (i >= 3) ? 1 : 0);
      chk($sformatf("push%0d_err", i), stack_err, (i == 4) ? 1 : 0);
    end
    do_reset();
    bus1_sel = 2'd2; sp_pop = 1;
    cycle();
    #1;
    chk("pop_empty_sp", to_memory, 8'hFF);
    chk("pop_empty_err", stack_err, 1);
    err_clr = 1;
    cycle();
    #1;
    chk("clr_with_err", stack_err, 1);
    sp_pop = 0;
    cycle();
    #1;
    chk("err_clr", stack_err, 0);
    err_clr = 0; sp_push = 1;
    cycle();
    sp_pop = 1;
    cycle();
    #1;
    chk("push_pop_sp", to_memory, 8'hFE);
    chk("push_pop_err", stack_err, 0);
`else
    do_reset();
    bus1_sel = 2'd2; sp_push = 1;
    cycle();
    #1;
    chk("nostack_bus1", to_memory, 0);
    chk("nostack_empty", sp_empty, 1);
    chk("nostack_err", stack_err, 0);
    chk("nostack_full", sp_full, 0);
`endif

    // Random traffic, including strobes on the first edge after reset release.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ir_load = 1'($urandom); mar_load = 1'($urandom);
      pc_load = ($urandom_range(0, 3) == 0); pc_inc = 1'($urandom);
      reg_load = 1'($urandom); ccr_load = 1'($urandom);
      reg_wsel = 2'($urandom); reg_asel = 2'($urandom); reg_bsel = 2'($urandom);
      bus1_sel = 2'($urandom); bus2_sel = 2'($urandom);
      alu_result = 8'($urandom); alu_nzvc = 4'($urandom); from_memory = 8'($urandom);
      sp_push = ($urandom_range(0, 2) == 0); sp_pop = ($urandom_range(0, 2) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      cycle();
      if (n == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
